// File: rtl/fifo_word_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_rd_pkg
// Description : Shared types and sizes for the FIFO read-side word packer.
//               BYTE_W     - width of one FIFO entry
//               WORD_BYTES - bytes packed per output word
//               CNT_W      - width of byte counters (holds 0..WORD_BYTES)
//               rd_state_e - packer state (FILL collects, HOLD presents)
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 3;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_word_reader_if.sv
`default_nettype none
// ============================================================================
// Interface   : fifo_word_reader_if
// Description : Bundles the FIFO read port and the packed-word stream.
//   fifo_empty  FIFO empty flag            (into the packer)
//   fifo_dout   FIFO read data, 1-cycle latency after fifo_rd_en
//   fifo_rd_en  FIFO pop request           (from the packer)
//   out_data    packed word, first byte in [7:0]
//   out_cnt     valid bytes in out_data
//   out_valid   word available
//   out_ready   downstream accepts
// Modports    : master - the packer; slave - FIFO/downstream side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_word_reader_if;
  import fifo_rd_pkg::*;

  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic [WORD_W-1:0] out_data;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_data, out_cnt, out_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_data, out_cnt, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/fifo_word_reader_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_idle_timer
// Description : Down-counter measuring consecutive idle cycles. Reloads to
//               TIMEOUT whenever count_i is low; expired_o pulses on the
//               TIMEOUT-th consecutive cycle with count_i high.
// Ports       : clk, rst (sync, active-high)
//               count_i   - idle condition for this cycle
//               expired_o - this cycle completes TIMEOUT idle cycles
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic count_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] remain_q;
  logic [CW-1:0] remain_d;

  always_comb begin
    remain_d = remain_q;
    if (!count_i) begin
      remain_d = CW'(TIMEOUT);
    end else if (remain_q > CW'(1)) begin
      remain_d = remain_q - CW'(1);
    end
  end

  // remain_q == 1 means this idle cycle is the last one allowed.
  assign expired_o = count_i && (remain_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q <= CW'(TIMEOUT);
    end else begin
      remain_q <= remain_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_word_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_reader
// Description : Read-side controller for the 8-bit FIFO. Pops bytes, packs
//               four of them little-endian into a 32-bit word and presents it
//               on a valid/ready stream.
// Ports       : clk     - single clock, rising edge
//               rst     - synchronous, active-high reset
//               rd_bus  - fifo_word_reader_if.master (FIFO read port and
//                         output word stream)
// Parameters  : TIMEOUT - idle cycles before a partial word is flushed
// Macro       : FIFO_RD_TIMEOUT_EN - enables partial-word flush after TIMEOUT
//               idle cycles; when undefined a partial word waits forever.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_reader
  import fifo_rd_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_word_reader_if.master  rd_bus
);

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              inflight_q, inflight_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              pop_req;

`ifdef FIFO_RD_TIMEOUT_EN
  logic idle;
  logic idle_expired;

  // Idle: a partial word is parked, nothing in flight, nothing to read.
  // Any pop or state change breaks the idle run and reloads the timer.
  assign idle = (state_q == FILL) && (byte_cnt_q != '0) &&
                (byte_cnt_q < CNT_W'(WORD_BYTES)) && !inflight_q &&
                rd_bus.fifo_empty;

  fifo_rd_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk       (clk),
    .rst       (rst),
    .count_i   (idle),
    .expired_o (idle_expired)
  );
`else
  // TIMEOUT only matters when partial-word flushing is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    inflight_d = 1'b0;
    pack_d     = pack_q;
    out_cnt_d  = out_cnt_q;
    pop_req    = 1'b0;

    case (state_q)
      FILL: begin
        // Captured plus in-flight bytes never exceed one word. Pops are
        // suppressed during reset so no byte is lost to the reset edge.
        pop_req = !rst && !rd_bus.fifo_empty &&
                  ((byte_cnt_q + CNT_W'(inflight_q)) < CNT_W'(WORD_BYTES));
        inflight_d = pop_req;

        if (inflight_q) begin
          for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_cnt_q == CNT_W'(i)) begin
              pack_d[i*BYTE_W +: BYTE_W] = rd_bus.fifo_dout;
            end
          end
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end

        // Move to HOLD on the capture of the last byte so the word is
        // presented in the very next cycle. No pop can be pending here.
        if (byte_cnt_d == CNT_W'(WORD_BYTES)) begin
          state_d   = HOLD;
          out_cnt_d = CNT_W'(WORD_BYTES);
        end
`ifdef FIFO_RD_TIMEOUT_EN
        else if (idle_expired) begin
          state_d   = HOLD;
          out_cnt_d = byte_cnt_q;
        end
`endif
      end

      HOLD: begin
        if (rd_bus.out_ready) begin
          state_d    = FILL;
          pack_d     = '0;
          byte_cnt_d = '0;
          out_cnt_d  = '0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      byte_cnt_q <= '0;
      inflight_q <= 1'b0;
      pack_q     <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      inflight_q <= inflight_d;
      pack_q     <= pack_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign rd_bus.fifo_rd_en = pop_req;
  assign rd_bus.out_data   = pack_q;
  assign rd_bus.out_cnt    = out_cnt_q;
  assign rd_bus.out_valid  = (state_q == HOLD);

endmodule
`default_nettype wire
